// File: rtl/gf2m_ld2aff571.sv
// rtl/gf2m_ld2aff571.sv - Lopez-Dahab (X:Y:Z) to affine (X/Z, Y/Z^2) converter over GF(2^571)
// Field polynomial x^571 + x^10 + x^5 + x^2 + 1; includes the multiplier, squarer and inverter it wraps.

module gf2m_mult571 #(
  parameter int LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [570:0] a,
  input  logic [570:0] b,
  output logic [570:0] p
);
  localparam logic [570:0] RED = 571'h425;

  logic [570:0] prod;
  logic [570:0] stage [LAT];

  // MSB-first shift-and-add, reducing on every shift
  always_comb begin
    prod = '0;
    for (int i = 570; i >= 0; i--) begin
      prod = {prod[569:0], 1'b0} ^ (prod[570] ? RED : '0);
      if (b[i]) prod = prod ^ a;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) stage[i] <= '0;
    end else begin
      stage[0] <= prod;
      for (int i = 1; i < LAT; i++) stage[i] <= stage[i-1];
    end
  end

  assign p = stage[LAT-1];
endmodule

module squerer_571 (
  input  logic [570:0] a,
  output logic [570:0] y
);
  logic [1140:0] w;

  // Spread bits to even positions, then fold the top half back down from the MSB
  always_comb begin
    w = '0;
    for (int i = 0; i < 571; i++) w[2*i] = a[i];
    for (int i = 1140; i >= 571; i--) begin
      if (w[i]) begin
        w[i-571] = w[i-571] ^ 1'b1;
        w[i-569] = w[i-569] ^ 1'b1;
        w[i-566] = w[i-566] ^ 1'b1;
        w[i-561] = w[i-561] ^ 1'b1;
      end
    end
    y = w[570:0];
  end
endmodule

module gf2m_inv571 (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [570:0] a,
  output logic         done,
  output logic [570:0] z
);
  // Addition chain on 570 = 10'b1000111010: beta_k = a^(2^k - 1), result = beta_570^2
  localparam logic [9:0] CHAIN = 10'd570;

  typedef enum logic [2:0] {I_IDLE, I_SQ, I_MUL, I_CAP, I_FIN, I_DONE} inv_state_t;
  inv_state_t   st;
  logic [570:0] a_r, beta, t, t_sq, p;
  logic [9:0]   k, n, k_next;
  logic [3:0]   idx;
  logic         sel_a;

  gf2m_mult571 #(.LAT(1)) u_mul (
    .clk (clk),
    .rst (rst),
    .a   (t),
    .b   (sel_a ? a_r : beta),
    .p   (p)
  );

  squerer_571 u_sq (.a(t), .y(t_sq));

  assign k_next = sel_a ? k + 10'd1 : {k[8:0], 1'b0};

  always_ff @(posedge clk) begin
    if (rst) begin
      st <= I_IDLE; done <= 1'b0; z <= '0; a_r <= '0; beta <= '0; t <= '0;
      k <= '0; n <= '0; idx <= '0; sel_a <= 1'b0;
    end else begin
      case (st)
        I_IDLE: if (start) begin
          a_r <= a; beta <= a; t <= a;
          k <= 10'd1; n <= 10'd1; idx <= 4'd8; sel_a <= 1'b0;
          st <= I_SQ;
        end
        I_SQ: begin
          t <= t_sq;
          n <= n - 10'd1;
          if (n == 10'd1) st <= I_MUL;
        end
        I_MUL: st <= I_CAP;
        I_CAP: begin
          beta <= p;
          t    <= p;
          if (!sel_a && CHAIN[idx]) begin
            k <= k_next; n <= 10'd1; sel_a <= 1'b1; st <= I_SQ;
          end else begin
            k <= k_next; n <= k_next; sel_a <= 1'b0;
            if (idx == 4'd0) st <= I_FIN;
            else begin
              idx <= idx - 4'd1;
              st  <= I_SQ;
            end
          end
        end
        I_FIN: begin
          z <= t_sq; done <= 1'b1; st <= I_DONE;
        end
        I_DONE: if (!start) begin
          done <= 1'b0; st <= I_IDLE;
        end
        default: st <= I_IDLE;
      endcase
    end
  end
endmodule

module gf2m_ld2aff571 #(
  parameter int MUL_LAT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [570:0] X,
  input  logic [570:0] Y,
  input  logic [570:0] Z,
  output logic [570:0] x_aff,
  output logic [570:0] y_aff,
  output logic         inf,
  output logic         busy,
  output logic         done
);
  localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MUL_LAT - 1);

  typedef enum logic [2:0] {IDLE, CHK, INV_WAIT, MUL_X, WAIT_X, MUL_Y, WAIT_Y, DONE} state_t;
  state_t       st;
  logic [570:0] xr, yr, zr, zi, zi_sq, inv_z, mul_a, mul_b, mul_res;
  logic [CW-1:0] cnt;
  logic         inv_start, inv_done;

  gf2m_inv571 u_inv (
    .clk   (clk),
    .rst   (rst),
    .start (inv_start),
    .a     (zr),
    .done  (inv_done),
    .z     (inv_z)
  );

  // Operands are registered, so the product is ready MUL_LAT-1 cycles into the wait
  gf2m_mult571 #(.LAT(MUL_LAT - 1)) u_mul (
    .clk (clk),
    .rst (rst),
    .a   (mul_a),
    .b   (mul_b),
    .p   (mul_res)
  );

  squerer_571 u_sq (.a(zi), .y(zi_sq));

  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE; x_aff <= '0; y_aff <= '0; inf <= 1'b0; busy <= 1'b0; done <= 1'b0;
      inv_start <= 1'b0; xr <= '0; yr <= '0; zr <= '0; zi <= '0;
      mul_a <= '0; mul_b <= '0; cnt <= '0;
    end else begin
      case (st)
        IDLE: begin
          done <= 1'b0;
          if (start && !inv_done) begin
            xr <= X; yr <= Y; zr <= Z; busy <= 1'b1; st <= CHK;
          end
        end
        CHK: if (zr == '0) begin
          x_aff <= '0; y_aff <= '0; inf <= 1'b1; st <= DONE;
        end else begin
          inf <= 1'b0; inv_start <= 1'b1; st <= INV_WAIT;
        end
        INV_WAIT: if (inv_done) begin
          zi <= inv_z; inv_start <= 1'b0; st <= MUL_X;
        end
        MUL_X: begin
          mul_a <= xr; mul_b <= zi; cnt <= '0; st <= WAIT_X;
        end
        WAIT_X: if (cnt == CNT_LAST) begin
          x_aff <= mul_res; st <= MUL_Y;
        end else cnt <= cnt + 1'b1;
        MUL_Y: begin
          mul_a <= yr; mul_b <= zi_sq; cnt <= '0; st <= WAIT_Y;
        end
        WAIT_Y: if (cnt == CNT_LAST) begin
          y_aff <= mul_res; st <= DONE;
        end else cnt <= cnt + 1'b1;
        DONE: begin
          done <= 1'b1; busy <= 1'b0; st <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gf2m_ld2aff571.sv
// tb/tb_gf2m_ld2aff571.sv - directed and random checks of the LD-to-affine converter
// Expected values come from hand-computed constants or an independent GF(2^571) model.

module tb_gf2m_ld2aff571;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [570:0] X = '0, Y = '0, Z = '0;
  logic [570:0] x_aff, y_aff;
  logic         inf, busy, done;

  int n_cmp = 0;
  int n_bad = 0;

  gf2m_ld2aff571 #(.MUL_LAT(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .X     (X),
    .Y     (Y),
    .Z     (Z),
    .x_aff (x_aff),
    .y_aff (y_aff),
    .inf   (inf),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  function automatic logic [570:0] ref_mul(input logic [570:0] a, input logic [570:0] b);
    logic [1140:0] w;
    w = '0;
    for (int i = 0; i < 571; i++)
      if (b[i]) w = w ^ ({570'b0, a} << i);
    for (int i = 1140; i >= 571; i--) begin
      if (w[i]) begin
        w[i] = 1'b0;
        w[i-571] = ~w[i-571];
        w[i-569] = ~w[i-569];
        w[i-566] = ~w[i-566];
        w[i-561] = ~w[i-561];
      end
    end
    return w[570:0];
  endfunction

  function automatic logic [570:0] rnd571();
    logic [575:0] r;
    r = '0;
    for (int i = 0; i < 18; i++) r = {r[543:0], $urandom()};
    return r[570:0];
  endfunction

  task automatic chk(input string tag, input logic [570:0] obs, input logic [570:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulses start for one cycle, then waits (bounded) for done; counts are negedges after acceptance
  task automatic run_conv(input logic [570:0] xv, input logic [570:0] yv, input logic [570:0] zv,
                          output int n_done, output int inv_at, output bit saw_inv);
    int n;
    @(negedge clk);
    X = xv; Y = yv; Z = zv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_accept", 571'(busy), 571'(1));
    n = 1; inv_at = -1; saw_inv = 1'b0;
    while (!done && n < 3000) begin
      if (dut.inv_start) saw_inv = 1'b1;
      if (dut.inv_done && inv_at < 0) inv_at = n;
      @(negedge clk);
      n++;
    end
    n_done = n;
    chk("done_seen", 571'(done), 571'(1));
    chk("busy_at_done", 571'(busy), 571'(0));
  endtask

  task automatic check_single_pulse();
    @(negedge clk);
    chk("done_single_pulse", 571'(done), 571'(0));
  endtask

  initial begin
    int nd, ia, nb;
    bit si;
    logic [570:0] xv, yv, zv, xb, yb, zb;

    repeat (3) @(negedge clk);
    chk("rst_x_aff", x_aff, '0);
    chk("rst_y_aff", y_aff, '0);
    chk("rst_inf", 571'(inf), 571'(0));
    chk("rst_busy", 571'(busy), 571'(0));
    chk("rst_done", 571'(done), 571'(0));
    rst = 1'b0;

    run_conv(571'd5, 571'd7, 571'd1, nd, ia, si);
    chk("z1_x", x_aff, 571'd5);
    chk("z1_y", y_aff, 571'd7);
    chk("z1_inf", 571'(inf), 571'(0));
    chk("z1_lat", 571'(nd - ia), 571'(12));
    check_single_pulse();

    run_conv(571'd4, 571'd8, 571'd2, nd, ia, si);
    chk("zx_x", x_aff, 571'd2);
    chk("zx_y", y_aff, 571'd2);
    chk("zx_lat", 571'(nd - ia), 571'(12));
    check_single_pulse();

    run_conv(571'h1234_5678_9abc, 571'h0fed_cba9, 571'd0, nd, ia, si);
    chk("z0_inf", 571'(inf), 571'(1));
    chk("z0_x", x_aff, '0);
    chk("z0_y", y_aff, '0);
    chk("z0_lat", 571'(nd), 571'(3));
    chk("z0_no_inv_start", 571'(si), 571'(0));
    check_single_pulse();

    for (int it = 0; it < 40; it++) begin
      xv = rnd571(); yv = rnd571(); zv = rnd571();
      if (zv == '0) zv = 571'd1;
      run_conv(xv, yv, zv, nd, ia, si);
      chk("rand_x", ref_mul(x_aff, zv), xv);
      chk("rand_y", ref_mul(y_aff, ref_mul(zv, zv)), yv);
      chk("rand_inf", 571'(inf), 571'(0));
      chk("rand_lat", 571'(nd - ia), 571'(12));
    end

    // Second start during INV_WAIT with different operands must be ignored
    xv = rnd571(); yv = rnd571(); zv = rnd571() | 571'd1;
    xb = rnd571(); yb = rnd571(); zb = rnd571() | 571'd2;
    @(negedge clk);
    X = xv; Y = yv; Z = zv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    X = xb; Y = yb; Z = zb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nb = 0;
    while (!done && nb < 3000) begin
      @(negedge clk);
      nb++;
    end
    chk("repulse_done_seen", 571'(done), 571'(1));
    chk("repulse_x", ref_mul(x_aff, zv), xv);
    chk("repulse_y", ref_mul(y_aff, ref_mul(zv, zv)), yv);
    check_single_pulse();
    chk("repulse_idle", 571'(busy), 571'(0));

    // Reset while the inverter is running
    @(negedge clk);
    X = rnd571(); Y = rnd571(); Z = 571'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    chk("pre_rst_inv_start", 571'(dut.inv_start), 571'(1));
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_x", x_aff, '0);
    chk("mid_rst_y", y_aff, '0);
    chk("mid_rst_inf", 571'(inf), 571'(0));
    chk("mid_rst_busy", 571'(busy), 571'(0));
    chk("mid_rst_done", 571'(done), 571'(0));
    chk("mid_rst_inv_start", 571'(dut.inv_start), 571'(0));
    run_conv(571'd5, 571'd7, 571'd1, nd, ia, si);
    chk("post_rst_x", x_aff, 571'd5);
    chk("post_rst_y", y_aff, 571'd7);

    // Back-to-back with start held high
    @(negedge clk);
    X = 571'd4; Y = 571'd8; Z = 571'd2; start = 1'b1;
    nb = 0;
    while (!done && nb < 3000) begin
      @(negedge clk);
      nb++;
    end
    chk("b2b1_done_seen", 571'(done), 571'(1));
    chk("b2b1_x", x_aff, 571'd2);
    chk("b2b1_y", y_aff, 571'd2);
    @(negedge clk);
    chk("b2b1_single_pulse", 571'(done), 571'(0));
    si = 1'b0;
    nb = 0;
    while (!done && nb < 3000) begin
      if (!dut.inv_start) si = 1'b1;
      @(negedge clk);
      nb++;
    end
    start = 1'b0;
    chk("b2b2_done_seen", 571'(done), 571'(1));
    chk("b2b2_inv_start_gap", 571'(si), 571'(1));
    chk("b2b2_x", x_aff, 571'd2);
    chk("b2b2_y", y_aff, 571'd2);
    @(negedge clk);
    chk("b2b2_single_pulse", 571'(done), 571'(0));
    @(negedge clk);
    chk("b2b_end_idle", 571'(busy), 571'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
